// File: rtl/tri3d_pkg.sv
// tri3d_pkg: shared vertex, triangle and scheduler state types for the projection sequencer
package tri3d_pkg;
  localparam int SCREEN_COORD_W = 10;
  typedef logic [31:0] vfloat_t;
  typedef logic [SCREEN_COORD_W-1:0] scoord_t;
  typedef struct packed {
    vfloat_t c_z, c_y, c_x, b_z, b_y, b_x, a_z, a_y, a_x;
  } tri3d_t;
  typedef struct packed {
    scoord_t c_y, c_x, b_y, b_x, a_y, a_x;
  } tri2d_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_COLLECT, S_EMIT, S_DONE} sched_state_t;
endpackage

// File: rtl/tri_result_collect.sv
// tri_result_collect: gathers three in-order projector results and times out missing ones
module tri_result_collect
  import tri3d_pkg::*;
#(
  parameter int PROJ_TIMEOUT = 64
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    clear,
  input  logic    accept,
  input  logic    load,
  input  logic    tick,
  input  logic    res_valid,
  input  scoord_t res_x,
  input  scoord_t res_y,
  output tri2d_t  tri2d,
  output logic    all_done,
  output logic    timed_out
);
  localparam int TW = $clog2(PROJ_TIMEOUT + 1);
  logic [1:0] k;
  logic [2:0][2*SCREEN_COORD_W-1:0] slot;
  logic [TW-1:0] tmo;
  always_ff @(posedge clk)
    if (rst || clear) begin
      k <= '0;
      slot <= '0;
      tmo <= '0;
    end else begin
      if (accept && res_valid && k != 2'd3) begin
        slot[k] <= {res_y, res_x};
        k <= k + 2'd1;
      end
      tmo <= load ? TW'(PROJ_TIMEOUT) : (tick && tmo != '0) ? tmo - TW'(1) : tmo;
    end
  assign tri2d = slot;
  assign all_done = k == 2'd3;
  assign timed_out = tmo == '0;
endmodule

// File: rtl/tri_project_sched.sv
// tri_project_sched: fetches 3D triangles, projects their vertices and streams 2D triangles
module tri_project_sched
  import tri3d_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2,
  parameter int PROJ_TIMEOUT = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] num_tris_in,
  input  logic [31:0]       camera_distance_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [15:0]       dropped_out,
  output logic [ADDR_W-1:0] tri_addr_out,
  input  logic [287:0]      tri_data_in,
  output logic              proj_valid_out,
  output logic [31:0]       proj_x_out,
  output logic [31:0]       proj_y_out,
  output logic [31:0]       proj_z_out,
  output logic [31:0]       proj_cam_dist_out,
  input  logic              proj_valid_in,
  input  logic [9:0]        proj_screen_x_in,
  input  logic [9:0]        proj_screen_y_in,
  output logic              tri_valid_out,
  input  logic              tri_ready_in,
  output logic [59:0]       tri_out,
  output logic [ADDR_W-1:0] tri_index_out
);
  localparam int WW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  sched_state_t state, next;
  logic [ADDR_W-1:0] idx, num;
  vfloat_t cam, vx, vy, vz;
  logic [15:0] dropped;
  tri3d_t hold;
  logic [WW-1:0] wcnt;
  logic [1:0] icnt;
  tri2d_t res;
  logic all_done, timed_out, issuing, read_ok, drop, last, advance;
  assign issuing = state == S_ISSUE;
  assign read_ok = state == S_WAIT && wcnt == WW'(RD_LAT - 1);
  assign drop = state == S_COLLECT && !all_done && timed_out;
  assign last = idx + ADDR_W'(1) == num;
  assign advance = drop || (state == S_EMIT && tri_ready_in);
  assign {vz, vy, vx} = icnt == 2'd0 ? {hold.a_z, hold.a_y, hold.a_x} :
                        icnt == 2'd1 ? {hold.b_z, hold.b_y, hold.b_x} : {hold.c_z, hold.c_y, hold.c_x};
  tri_result_collect #(.PROJ_TIMEOUT(PROJ_TIMEOUT)) u_collect (
    .clk(clk_in),
    .rst(rst_in),
    .clear(state == S_FETCH),
    .accept(issuing || state == S_COLLECT),
    .load(issuing && icnt == 2'd2),
    .tick(state == S_COLLECT),
    .res_valid(proj_valid_in),
    .res_x(proj_screen_x_in),
    .res_y(proj_screen_y_in),
    .tri2d(res),
    .all_done(all_done),
    .timed_out(timed_out)
  );
  always_ff @(posedge clk_in)
    if (rst_in) begin
      state <= S_IDLE;
      idx <= '0;
      num <= '0;
      cam <= '0;
      dropped <= '0;
      hold <= '0;
      wcnt <= '0;
      icnt <= '0;
    end else begin
      state <= next;
      if (state == S_IDLE && start_in) begin
        num <= num_tris_in;
        cam <= camera_distance_in;
        dropped <= '0;
        idx <= '0;
      end else if (advance && !last) idx <= idx + ADDR_W'(1);
      wcnt <= state == S_WAIT ? wcnt + WW'(1) : '0;
      if (read_ok) hold <= tri_data_in;
      icnt <= issuing ? icnt + 2'd1 : 2'd0;
      if (drop && dropped != 16'hffff) dropped <= dropped + 16'd1;
    end
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:    next = start_in ? (num_tris_in == '0 ? S_DONE : S_FETCH) : S_IDLE;
      S_FETCH:   next = S_WAIT;
      S_WAIT:    next = read_ok ? S_ISSUE : S_WAIT;
      S_ISSUE:   next = icnt == 2'd2 ? S_COLLECT : S_ISSUE;
      S_COLLECT: next = all_done ? S_EMIT : drop ? (last ? S_DONE : S_FETCH) : S_COLLECT;
      S_EMIT:    next = tri_ready_in ? (last ? S_DONE : S_FETCH) : S_EMIT;
      S_DONE:    next = S_IDLE;
      default:   next = S_IDLE;
    endcase
  end
  assign busy_out = state != S_IDLE && state != S_DONE;
  assign done_out = state == S_DONE;
  assign dropped_out = dropped;
  assign tri_addr_out = idx;
  assign proj_valid_out = issuing;
  assign proj_x_out = issuing ? vx : '0;
  assign proj_y_out = issuing ? vy : '0;
  assign proj_z_out = issuing ? vz : '0;
  assign proj_cam_dist_out = cam;
  assign tri_valid_out = state == S_EMIT;
  assign tri_out = tri_valid_out ? res : '0;
  assign tri_index_out = tri_valid_out ? idx : '0;
endmodule

// File: tb/tb_tri_project_sched.sv
// tb_tri_project_sched: scoreboard bench with BRAM and fixed-latency projector models
module tb_tri_project_sched;
  localparam int AW = 10;
  logic clk = 0, rst, start, ready, pv_in;
  logic [AW-1:0] num_tris, tri_addr, tri_index;
  logic [31:0] cam_in, px, py, pz, pcam;
  logic [287:0] d1, d2;
  logic [9:0] sx = '0, sy = '0;
  logic busy, done, pv_out, tri_valid;
  logic [15:0] dropped;
  logic [59:0] tri_o, held_tri;
  logic [AW-1:0] held_idx;
  int errors = 0, checks = 0, cyc = 0;
  int done_cnt = 0, xfer_cnt = 0, pv_cnt = 0;
  int lat, drop_idx, drop_v, vnum, stall_idx, stall_len, stall_used;
  int d0, x0, p0, n;
  bit prev_stall;
  typedef struct {int due; logic [9:0] x, y;} res_t;
  res_t mq[$];
  res_t r;
  logic [127:0] iq[$];
  logic [69:0] sq[$];

  always #5 clk = ~clk;

  tri_project_sched dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .num_tris_in(num_tris),
    .camera_distance_in(cam_in), .busy_out(busy), .done_out(done), .dropped_out(dropped),
    .tri_addr_out(tri_addr), .tri_data_in(d2), .proj_valid_out(pv_out),
    .proj_x_out(px), .proj_y_out(py), .proj_z_out(pz), .proj_cam_dist_out(pcam),
    .proj_valid_in(pv_in), .proj_screen_x_in(sx), .proj_screen_y_in(sy),
    .tri_valid_out(tri_valid), .tri_ready_in(ready), .tri_out(tri_o), .tri_index_out(tri_index)
  );

  function automatic logic [9:0] scr(int t, int f);
    return 10'((t * 40 + f * 4 + 1) & 1023);
  endfunction
  function automatic logic [31:0] vf(int t, int f);
    return 32'h3f80_0000 | (32'(t) << 16) | 32'(scr(t, f));
  endfunction
  function automatic logic [287:0] word(int t);
    logic [287:0] w;
    for (int f = 0; f < 9; f++) w[f*32 +: 32] = vf(t, f);
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_tri(input int t, input bit emit, input logic [31:0] c);
    for (int v = 0; v < 3; v++) iq.push_back({vf(t, 3*v), vf(t, 3*v+1), vf(t, 3*v+2), c});
    if (emit) sq.push_back({10'(t), scr(t, 7), scr(t, 6), scr(t, 4), scr(t, 3), scr(t, 1), scr(t, 0)});
  endtask

  task automatic pulse(input int num, input logic [31:0] c);
    @(posedge clk); #1;
    start = 1; num_tris = AW'(num); cam_in = c;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int s = done_cnt, k = 0;
    while (done_cnt == s && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (done_cnt == s) begin
      errors++;
      $display("FAIL %s: done_out not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_dropped"}, dropped, 0);
    check({tag, "_addr"}, tri_addr, 0);
    check({tag, "_pvalid"}, pv_out, 0);
    check({tag, "_px"}, px, 0);
    check({tag, "_cam"}, pcam, 0);
    check({tag, "_tvalid"}, tri_valid, 0);
    check({tag, "_tri"}, {tri_index, tri_o}, 0);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    d1 <= word(int'(tri_addr));
    d2 <= d1;
  end

  // Projector model: fixed latency, optionally discarding one chosen vertex
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      vnum = 0;
      pv_in = 0;
    end else begin
      if (pv_out) begin
        if (!(int'(tri_addr) == drop_idx && vnum == drop_v)) mq.push_back('{cyc + lat, px[9:0], py[9:0]});
        vnum = (vnum + 1) % 3;
      end
      pv_in = 0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        r = mq.pop_front();
        pv_in = 1;
        sx = r.x;
        sy = r.y;
      end
    end
  end

  // Monitor: ready generation, issue and triangle scoreboards, stall stability
  always @(negedge clk) begin
    if (rst) begin
      ready = 1;
      prev_stall = 0;
      stall_used = 0;
    end else begin
      if (pv_out) begin
        pv_cnt++;
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_extra: unexpected issue x=%0h expected none", px);
        end else check("issue", {px, py, pz, pcam}, iq.pop_front());
      end
      if (done) done_cnt++;
      if (prev_stall) begin
        check("stall_tri", tri_o, held_tri);
        check("stall_idx", tri_index, held_idx);
      end
      ready = !(tri_valid && int'(tri_index) == stall_idx && stall_used < stall_len);
      if (!ready) stall_used++;
      prev_stall = tri_valid && !ready;
      held_tri = tri_o;
      held_idx = tri_index;
      if (tri_valid && ready) begin
        xfer_cnt++;
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL tri_extra: unexpected triangle idx=%0d expected none", tri_index);
        end else check("tri", {tri_index, tri_o}, sq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; num_tris = '0; cam_in = '0;
    lat = 20; drop_idx = -1; drop_v = 0; stall_idx = -1; stall_len = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 0;

    push_tri(0, 1, 32'h4120_0000);
    d0 = done_cnt; x0 = xfer_cnt;
    pulse(1, 32'h4120_0000);
    wait_done(500, "t1_done");
    repeat (5) @(negedge clk);
    check("t1_dropped", dropped, 0);
    check("t1_xfers", xfer_cnt - x0, 1);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_busy", busy, 0);

    stall_idx = 2; stall_len = 10;
    for (int t = 0; t < 4; t++) push_tri(t, 1, 32'h4220_0000);
    x0 = xfer_cnt;
    pulse(4, 32'h4220_0000);
    wait_done(1000, "t2_done");
    check("t2_xfers", xfer_cnt - x0, 4);
    check("t2_stalled", stall_used, 10);
    check("t2_sb_empty", sq.size(), 0);
    stall_idx = -1;

    drop_idx = 1; drop_v = 1;
    for (int t = 0; t < 3; t++) push_tri(t, t != 1, 32'h4040_0000);
    x0 = xfer_cnt;
    pulse(3, 32'h4040_0000);
    wait_done(2000, "t3_done");
    check("t3_dropped", dropped, 1);
    check("t3_xfers", xfer_cnt - x0, 2);
    check("t3_sb_empty", sq.size(), 0);
    drop_idx = -1;

    d0 = done_cnt; x0 = xfer_cnt; p0 = pv_cnt;
    @(posedge clk); #1;
    start = 1; num_tris = '0; cam_in = 32'h4080_0000;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("zero_done_once", done_cnt - d0, 1);
    check("zero_issues", pv_cnt - p0, 0);
    check("zero_xfers", xfer_cnt - x0, 0);

    lat = 40;
    push_tri(0, 0, 32'h40a0_0000);
    d0 = done_cnt; p0 = pv_cnt;
    pulse(1, 32'h40a0_0000);
    n = 0;
    while (pv_cnt - p0 < 3 && n < 200) begin @(negedge clk); n++; end
    check("rst_issues_seen", pv_cnt - p0, 3);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_idle("midrst");
    repeat (60) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_emit", tri_valid, 0);

    lat = 20;
    for (int t = 0; t < 2; t++) push_tri(t, 1, 32'h40c0_0000);
    x0 = xfer_cnt;
    pulse(2, 32'h40c0_0000);
    wait_done(1000, "post_rst_done");
    check("post_rst_xfers", xfer_cnt - x0, 2);

    for (int t = 0; t < 2; t++) push_tri(t, 1, 32'h40e0_0000);
    d0 = done_cnt; x0 = xfer_cnt;
    pulse(2, 32'h40e0_0000);
    repeat (4) @(posedge clk);
    pulse(5, 32'h4100_0000);
    wait_done(1000, "restart_done");
    repeat (100) @(negedge clk);
    check("restart_xfers", xfer_cnt - x0, 2);
    check("restart_done_once", done_cnt - d0, 1);
    check("restart_iq_empty", iq.size(), 0);
    check("restart_sq_empty", sq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
